// File: rtl/boot_mem_arbiter_pkg.sv
// Shared encodings for the boot/scan/CPU RAM arbiter: mode values and
// requester owner ids used to route read-valid back to the right port.
package boot_mem_arbiter_pkg;

   localparam logic [1:0] MODE_RUN  = 2'd0;
   localparam logic [1:0] MODE_BOOT = 2'd1;
   localparam logic [1:0] MODE_SCAN = 2'd2;

   localparam logic [1:0] ID_CPU  = 2'd0;
   localparam logic [1:0] ID_BOOT = 2'd1;
   localparam logic [1:0] ID_SCAN = 2'd2;

endpackage

// File: rtl/boot_mem_arbiter.sv
// Single-port RAM arbiter between CPU, UART bootloader and scan dump reader.
// A registered mode FSM gives BOOT/SCAN exclusive access and halts the CPU;
// in RUN the CPU has priority, with a saturating wait counter that forces a
// scan grant after MAX_WAIT consecutive CPU wins.
module boot_mem_arbiter
   import boot_mem_arbiter_pkg::*;
#(
   parameter int ADDR_W   = 8,
   parameter int DATA_W   = 8,
   parameter int MAX_WAIT = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ce,
   input  logic              boot_start,
   input  logic              boot_done,
   input  logic              scan_mode,
   output logic              cpu_halt,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_rvalid,
   input  logic              boot_req,
   input  logic              boot_we,
   input  logic [ADDR_W-1:0] boot_addr,
   input  logic [DATA_W-1:0] boot_wdata,
   output logic              boot_gnt,
   output logic              boot_rvalid,
   input  logic              scan_req,
   input  logic              scan_we,
   input  logic [ADDR_W-1:0] scan_addr,
   input  logic [DATA_W-1:0] scan_wdata,
   output logic              scan_gnt,
   output logic              scan_rvalid,
   output logic [DATA_W-1:0] rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

   logic [1:0] mode;
   logic [1:0] mode_nxt;
   logic [7:0] wait_cnt;
   logic [7:0] wait_cnt_nxt;

   // read-return pipe: valid and owner of the access issued last cycle
   logic       vld_p1;
   logic [1:0] id_p1;
   logic       rd_issue;
   logic [1:0] rd_id;

   // grant decision from registered mode/counter and the live requests
   always_comb begin
      cpu_gnt  = 1'b0;
      boot_gnt = 1'b0;
      scan_gnt = 1'b0;
      if (!rst && ce) begin
         case (mode)
            MODE_BOOT: boot_gnt = boot_req;
            MODE_SCAN: scan_gnt = scan_req;
            default: begin
               if (scan_req && (!cpu_req || wait_cnt == MAX_WAIT_C))
                  scan_gnt = 1'b1;
               else
                  cpu_gnt = cpu_req;
            end
         endcase
      end
   end

   // RAM port driven straight from the single winner
   always_comb begin
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      rd_id     = ID_CPU;
      if (cpu_gnt) begin
         mem_we    = cpu_we;
         mem_addr  = cpu_addr;
         mem_wdata = cpu_wdata;
         rd_id     = ID_CPU;
      end else if (boot_gnt) begin
         mem_we    = boot_we;
         mem_addr  = boot_addr;
         mem_wdata = boot_wdata;
         rd_id     = ID_BOOT;
      end else if (scan_gnt) begin
         mem_we    = scan_we;
         mem_addr  = scan_addr;
         mem_wdata = scan_wdata;
         rd_id     = ID_SCAN;
      end
   end

   assign mem_en   = cpu_gnt | boot_gnt | scan_gnt;
   assign rd_issue = mem_en & ~mem_we;
   assign rdata    = mem_rdata;
   assign cpu_halt = (mode != MODE_RUN);

   // next mode; boot_start outranks scan_mode when leaving RUN
   always_comb begin
      mode_nxt = mode;
      case (mode)
         MODE_RUN: begin
            if (boot_start)
               mode_nxt = MODE_BOOT;
            else if (scan_mode)
               mode_nxt = MODE_SCAN;
         end
         MODE_BOOT: if (boot_done)  mode_nxt = MODE_RUN;
         MODE_SCAN: if (!scan_mode) mode_nxt = MODE_RUN;
         default:   mode_nxt = MODE_RUN;
      endcase
   end

   // starvation counter: counts CPU wins while scan waits, only inside RUN
   always_comb begin
      wait_cnt_nxt = wait_cnt;
      if (mode != MODE_RUN || mode_nxt != MODE_RUN)
         wait_cnt_nxt = '0;
      else if (scan_gnt || !scan_req)
         wait_cnt_nxt = '0;
      else if (cpu_gnt && wait_cnt != MAX_WAIT_C)
         wait_cnt_nxt = wait_cnt + 8'd1;
   end

   // mode and counter state, frozen while ce is low
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode     <= MODE_RUN;
         wait_cnt <= '0;
      end else if (ce) begin
         mode     <= mode_nxt;
         wait_cnt <= wait_cnt_nxt;
      end
   end

   // ---- stage p0 -> p1: read issued, data returns next cycle ----
   // valid flag of the outstanding read; not gated by ce so it always drains
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         vld_p1 <= 1'b0;
      else
         vld_p1 <= rd_issue;
   end

   // owner of the outstanding read, only meaningful when vld_p1 is set
   always_ff @(posedge clk) begin
      id_p1 <= rd_id;
   end

   assign cpu_rvalid  = vld_p1 && (id_p1 == ID_CPU);
   assign boot_rvalid = vld_p1 && (id_p1 == ID_BOOT);
   assign scan_rvalid = vld_p1 && (id_p1 == ID_SCAN);

endmodule
